cw_decoder: RTL and testbench
=============================

Name: cw_decoder

Overview:
- Constant-weight-word-to-binary decoder. It is the inverse of the encoder in the 20-8 constant-weight coding datapath.
- Consumes a stream of gap values: the distances between successive nonzero positions of a weight-t word of length n.
- Emits the recovered message bits serially, MSB-first per field.
- Recomputes (d, u) from the current (n, t) with exactly the same rule as the encoder, so the two ends stay bit-exact.

Parameters:
- N_W, 21: width of n and gap values.
- T_W, 4: width of t.
- U_MAX, 19: maximum u (d capped at 2^U_MAX).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; loads n_init/t_init when idle.
- n_init  in  N_W  initial code length n.
- t_init  in  T_W  initial weight t (1..8).
- gap  in  N_W  next gap value.
- gap_valid  in  1  gap is valid.
- gap_ready  out  1  decoder accepts gap this cycle.
- bit_out  out  1  decoded message bit.
- bit_valid  out  1  bit_out is valid.
- bit_ready  in  1  downstream accepts bit.
- bit_last  out  1  qualifies the final bit of the message.
- busy  out  1  decode in progress.
- done  out  1  one-cycle pulse after the final bit is accepted.

Behaviour:
- Reset: gap_ready=0, bit_out=0, bit_valid=0, bit_last=0, busy=0, done=0; state=IDLE.
- Reset is synchronous and active-high, and overrides everything including mid-decode. No partial output follows reset.
- theta from t:
  - t>=6 → 1
  - t=4,5 → 2
  - t=3 → 3
  - t=2 → 4
  - t<=1 → 8
- d/u computation:
  - q = (n*theta)>>4, computed at full 25-bit product width.
  - u=19 if q>2^18; else u=k where 2^(k-1) < q <= 2^k, for k in 3..18; u=2 if q<=4.
  - d = 2^u.
- d/u latency: registered theta then registered d/u, i.e. 2 cycles after n/t change. The FSM waits in CALC for 2 cycles before every DECIDE.
- FSM states:
  - IDLE: busy=0. On start, n←n_init, t←t_init, go to GET. start while busy is ignored.
  - GET: gap_ready=1. On gap_valid&gap_ready, delta←gap, go to CALC.
  - CALC: 2-cycle counter, then DECIDE.
  - DECIDE (delta>=d): present bit 1; delta←delta−d; n←n−d; after accept go to CALC.
  - DECIDE (delta<d): present bit 0, then EMIT.
  - EMIT: present the u low bits of delta, MSB first (bit u−1 down to 0). After the last is accepted: n←n−delta−1, t←t−1. If t==0, go to DONE; else go to GET.
  - DONE: done=1 for one cycle, then IDLE.
- Output handshake:
  - A bit transfers on bit_valid&bit_ready.
  - bit_out and bit_last are held stable while bit_valid=1 and bit_ready=0.
  - No bubble is required between consecutive EMIT bits.
- bit_last=1 only on the final EMIT bit of the t-th gap.
- Arithmetic:
  - n and delta are unsigned N_W bits.
  - Input contract: gap < n at fetch. Values violating this give undefined output without CW_DEC_ERR_EN.
  - n never wraps for legal input.
- gap_ready is 0 in every state except GET. gap_valid outside GET is ignored.

Optional Feature:
- Macro: CW_DEC_ERR_EN.
- Defined: adds output port err (1 bit, reset 0).
  - err is set and the decoder aborts to IDLE (no further bits, no done) if a fetched gap >= n.
  - err is also set on the same condition if t_init==0 at start.
  - err is sticky until rst or the next accepted start.
- Undefined: no err port and no checks.

Test Plan:
- Basic decode: start, n_init=20, t_init=2; gaps 10 then 5; bit_ready=1.
  - Expected bits: 1,0,1,0 | 1,0,0,1 (8 bits).
  - bit_last on the 8th bit; done one cycle after; busy=0.
- Single-weight decode: n_init=1000, t_init=1; gap 3 (u=9).
  - Expected bits: 0,0,0,0,0,0,0,0,1,1 (10 bits); done.
- Backpressure: same as the basic decode, bit_ready toggled 1/0 every cycle.
  - Identical bit sequence; bit_out stable during every stall.
  - gap_ready asserted only in GET.
- Reset mid-operation: assert rst during the 3rd bit of the basic decode.
  - All outputs return to reset values the next cycle.
  - A fresh start reproduces the full 8-bit sequence.
- start while busy: pulse start with n_init=1000 in mid-decode of the basic decode.
  - Ignored; output is unchanged.
- Error check (CW_DEC_ERR_EN): n_init=20, t_init=2, gap=20.
  - err=1, no bit_valid, no done.
  - The next valid start clears err.

Source files
------------

// File: rtl/cw_decoder.sv
// Constant-weight-word to binary decoder: turns a stream of gap values back into message bits.
// Optional macro CW_DEC_ERR_EN adds a sticky err output and aborts on illegal gaps or t_init==0.
module cw_decoder #(
    parameter int N_W   = 21,
    parameter int T_W   = 4,
    parameter int U_MAX = 19
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N_W-1:0] n_init,
    input  logic [T_W-1:0] t_init,
    input  logic [N_W-1:0] gap,
    input  logic           gap_valid,
    output logic           gap_ready,
    output logic           bit_out,
    output logic           bit_valid,
    input  logic           bit_ready,
    output logic           bit_last,
    output logic           busy,
    output logic           done
`ifdef CW_DEC_ERR_EN
    ,
    output logic           err
`endif
);

    localparam int U_W = $clog2(U_MAX + 1);
    localparam int P_W = N_W + T_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET,
        S_CALC,
        S_DECIDE,
        S_EMIT,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [N_W-1:0] n_q, n_d;
    logic [T_W-1:0] t_q, t_d;
    logic [N_W-1:0] delta_q, delta_d;
    logic           cnt_q, cnt_d;
    logic [U_W-1:0] idx_q, idx_d;
`ifdef CW_DEC_ERR_EN
    logic           err_q, err_d;
`endif

    logic [T_W-1:0] theta_calc, theta_q;
    logic [P_W-1:0] prod;
    logic [N_W-1:0] q;
    logic [U_W-1:0] u_calc, u_q;
    logic [N_W-1:0] d_calc, d_q;

    // theta and (d, u) use the same rule as the encoder, so both ends agree bit for bit.
    always_comb begin
        if (t_q >= T_W'(6))      theta_calc = T_W'(1);
        else if (t_q >= T_W'(4)) theta_calc = T_W'(2);
        else if (t_q == T_W'(3)) theta_calc = T_W'(3);
        else if (t_q == T_W'(2)) theta_calc = T_W'(4);
        else                     theta_calc = T_W'(8);
    end

    always_comb begin
        prod   = P_W'(n_q) * P_W'(theta_q);
        q      = N_W'(prod >> 4);
        u_calc = U_W'(2);
        // Largest k with q > 2^(k-1) is the smallest k with 2^k >= q.
        for (int k = 3; k <= U_MAX; k++) begin
            if (q > (N_W'(1) << (k - 1))) u_calc = U_W'(k);
        end
        d_calc = N_W'(1) << u_calc;
    end

    // NOTE: the theta/d/u pipeline carries no reset; the FSM always spends two CALC
    // cycles before consuming it, so its contents after reset never matter.
    always_ff @(posedge clk) begin
        theta_q <= theta_calc;
        u_q     <= u_calc;
        d_q     <= d_calc;
    end

    // NOTE: state registers use non-blocking assignments and a synchronous active-high
    // reset; blocking assignments here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            t_q     <= '0;
            delta_q <= '0;
            cnt_q   <= 1'b0;
            idx_q   <= '0;
`ifdef CW_DEC_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            t_q     <= t_d;
            delta_q <= delta_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
`ifdef CW_DEC_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    // NOTE: every signal written below gets a default first, so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        t_d       = t_q;
        delta_d   = delta_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
`ifdef CW_DEC_ERR_EN
        err_d     = err_q;
`endif
        gap_ready = 1'b0;
        bit_out   = 1'b0;
        bit_valid = 1'b0;
        bit_last  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d     = n_init;
                    t_d     = t_init;
                    state_d = S_GET;
`ifdef CW_DEC_ERR_EN
                    err_d   = 1'b0;
                    if (t_init == '0) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
`endif
                end
            end
            S_GET: begin
                busy      = 1'b1;
                gap_ready = 1'b1;
                if (gap_valid) begin
                    delta_d = gap;
                    cnt_d   = 1'b0;
                    state_d = S_CALC;
`ifdef CW_DEC_ERR_EN
                    if (gap >= n_q) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
`endif
                end
            end
            S_CALC: begin
                busy  = 1'b1;
                cnt_d = ~cnt_q;
                if (cnt_q) state_d = S_DECIDE;
            end
            S_DECIDE: begin
                busy      = 1'b1;
                bit_valid = 1'b1;
                bit_out   = (delta_q >= d_q);
                if (bit_ready) begin
                    if (delta_q >= d_q) begin
                        delta_d = delta_q - d_q;
                        n_d     = n_q - d_q;
                        cnt_d   = 1'b0;
                        state_d = S_CALC;
                    end else begin
                        idx_d   = u_q - U_W'(1);
                        state_d = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                busy      = 1'b1;
                bit_valid = 1'b1;
                bit_out   = delta_q[idx_q];
                bit_last  = (idx_q == '0) && (t_q == T_W'(1));
                if (bit_ready) begin
                    if (idx_q == '0) begin
                        n_d     = n_q - delta_q - N_W'(1);
                        t_d     = t_q - T_W'(1);
                        state_d = (t_q == T_W'(1)) ? S_DONE : S_GET;
                    end else begin
                        idx_d = idx_q - U_W'(1);
                    end
                end
            end
            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef CW_DEC_ERR_EN
    assign err = err_q;
`endif

endmodule

// File: tb/tb_cw_decoder.sv
// Self-checking bench for cw_decoder: fixed vectors, corner sequences and random traffic
// checked against a gap-by-gap arithmetic model of the decoding rule.
module tb_cw_decoder;

    localparam int N_W = 21;
    localparam int T_W = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [N_W-1:0] n_init;
    logic [T_W-1:0] t_init;
    logic [N_W-1:0] gap;
    logic           gap_valid;
    logic           gap_ready;
    logic           bit_out;
    logic           bit_valid;
    logic           bit_ready;
    logic           bit_last;
    logic           busy;
    logic           done;
`ifdef CW_DEC_ERR_EN
    logic           err;
`endif

    cw_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .n_init    (n_init),
        .t_init    (t_init),
        .gap       (gap),
        .gap_valid (gap_valid),
        .gap_ready (gap_ready),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .bit_last  (bit_last),
        .busy      (busy),
        .done      (done)
`ifdef CW_DEC_ERR_EN
        ,
        .err       (err)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int unsigned gap_q[$];
    bit          exp_q[$];

    typedef struct {
        int unsigned n;
        int unsigned t;
        int          ng;
        int unsigned g0;
        int unsigned g1;
        int          nb;
        logic [63:0] bits;
        int          mode;
        string       name;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Reference: per gap, repeatedly strip d while delta >= d, then send 0 and the u-bit remainder.
    function automatic void build_expected(input longint n0, input int t0);
        longint n = n0;
        int     t = t0;
        exp_q = {};
        foreach (gap_q[i]) begin
            longint delta = gap_q[i];
            forever begin
                longint theta, qv, d;
                int u;
                theta = (t >= 6) ? 1 : (t >= 4) ? 2 : (t == 3) ? 3 : (t == 2) ? 4 : 8;
                qv = (n * theta) / 16;
                if (qv > (64'd1 << 18)) u = 19;
                else begin
                    u = 2;
                    while ((64'd1 << u) < qv) u++;
                end
                d = 64'd1 << u;
                if (delta >= d) begin
                    exp_q.push_back(1'b1);
                    delta -= d;
                    n -= d;
                end else begin
                    exp_q.push_back(1'b0);
                    for (int b = u - 1; b >= 0; b--) exp_q.push_back(bit'((delta >> b) & 1));
                    n -= delta + 1;
                    t--;
                    break;
                end
            end
        end
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_gap_ready"}, gap_ready, 0);
        check({tag, "_bit_out"},   bit_out,   0);
        check({tag, "_bit_valid"}, bit_valid, 0);
        check({tag, "_bit_last"},  bit_last,  0);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_done"},      done,      0);
    endtask

    // mode 0: bit_ready always 1; mode 1: toggling; mode 2: random with junk gap_valid outside GET.
    task automatic run_decode(input int unsigned n0, input int unsigned t0, input int mode,
                              input int abort_bit, input bit inj_start, input string name,
                              output bit aborted);
        int   gi = 0;
        int   bi = 0;
        bit   finished = 1'b0;
        bit   prev_stall = 1'b0;
        logic prev_bit = 1'b0;
        bit   injected = 1'b0;
        aborted = 1'b0;
        @(negedge clk);
        start  = 1'b1;
        n_init = n0[N_W-1:0];
        t_init = t0[T_W-1:0];
        for (int cyc = 0; cyc < 20000 && !finished && !aborted; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (prev_stall) begin
                check({name, "_stall_valid"}, bit_valid, 1);
                check({name, "_stall_hold"},  bit_out,   prev_bit);
            end
            if (gap_ready) check({name, "_gap_ready_excl"}, bit_valid, 0);
            if (done) begin
                check({name, "_bit_count"}, bi, exp_q.size());
                check({name, "_gap_count"}, gi, gap_q.size());
                finished   = 1'b1;
                gap_valid  = 1'b0;
                bit_ready  = 1'b0;
                prev_stall = 1'b0;
            end else if (abort_bit >= 0 && bi == abort_bit && bit_valid) begin
                rst       = 1'b1;
                gap_valid = 1'b0;
                bit_ready = 1'b0;
                aborted   = 1'b1;
            end else begin
                if (inj_start && !injected && bi == 3 && busy) begin
                    start    = 1'b1;
                    n_init   = 21'd1000;
                    t_init   = 4'd2;
                    injected = 1'b1;
                end
                if (gap_ready) begin
                    gap_valid = (gi < gap_q.size());
                    gap       = (gi < gap_q.size()) ? gap_q[gi][N_W-1:0] : '0;
                    if (gi < gap_q.size()) gi++;
                end else begin
                    gap_valid = (mode != 0) ? 1'($urandom % 2) : 1'b0;
                    gap       = N_W'($urandom);
                end
                case (mode)
                    0:       bit_ready = 1'b1;
                    1:       bit_ready = (cyc % 2) == 0;
                    default: bit_ready = ($urandom % 4) != 0;
                endcase
                if (bit_valid && bit_ready) begin
                    check({name, "_bit"}, bit_out, (bi < exp_q.size()) ? 32'(exp_q[bi]) : 32'hx);
                    check({name, "_last"}, bit_last, 32'(bi == exp_q.size() - 1));
                    bi++;
                end
                prev_stall = bit_valid && !bit_ready;
                prev_bit   = bit_out;
            end
        end
        start = 1'b0;
        if (!aborted) begin
            check({name, "_finished"}, finished, 1);
            if (finished) begin
                @(negedge clk);
                check({name, "_busy_after"}, busy, 0);
                check({name, "_done_pulse"}, done, 0);
            end
        end
    endtask

    task automatic load_vec(input int idx);
        gap_q = {};
        gap_q.push_back(vecs[idx].g0);
        if (vecs[idx].ng > 1) gap_q.push_back(vecs[idx].g1);
        exp_q = {};
        for (int i = vecs[idx].nb - 1; i >= 0; i--) exp_q.push_back(vecs[idx].bits[i]);
    endtask

    initial begin
        bit ab;
        vecs[0] = '{n: 20,      t: 2, ng: 2, g0: 10, g1: 5,  nb: 8,  bits: 64'b10101001,   mode: 0, name: "basic"};
        vecs[1] = '{n: 1000,    t: 1, ng: 1, g0: 3,  g1: 0,  nb: 10, bits: 64'b0000000011, mode: 0, name: "single"};
        vecs[2] = '{n: 20,      t: 2, ng: 2, g0: 10, g1: 5,  nb: 8,  bits: 64'b10101001,   mode: 1, name: "backpressure"};
        vecs[3] = '{n: 16,      t: 1, ng: 1, g0: 15, g1: 0,  nb: 5,  bits: 64'b11011,      mode: 0, name: "gap_max"};
        vecs[4] = '{n: 20,      t: 2, ng: 2, g0: 0,  g1: 18, nb: 8,  bits: 64'b00001010,   mode: 2, name: "gap_zero"};
        vecs[5] = '{n: 2000000, t: 1, ng: 1, g0: 1,  g1: 0,  nb: 20, bits: 64'd1,          mode: 0, name: "u_max"};

        rst = 1'b1; start = 1'b0; n_init = '0; t_init = '0;
        gap = '0; gap_valid = 1'b0; bit_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            load_vec(i);
            run_decode(vecs[i].n, vecs[i].t, vecs[i].mode, -1, 1'b0, vecs[i].name, ab);
        end

        // Reset while the third bit is presented, then a clean rerun.
        load_vec(0);
        run_decode(20, 2, 0, 2, 1'b0, "mid_reset", ab);
        check("mid_reset_aborted", ab, 1);
        @(negedge clk);
        check_idle_outputs("mid_reset");
        rst = 1'b0;
        run_decode(20, 2, 0, -1, 1'b0, "after_reset", ab);

        load_vec(0);
        run_decode(20, 2, 0, -1, 1'b1, "start_busy", ab);

        for (int r = 0; r < 40; r++) begin
            int unsigned n0, t0, n, g, maxg;
            n0 = $urandom_range(2097151, 16);
            t0 = $urandom_range(8, 1);
            n  = n0;
            gap_q = {};
            for (int i = 0; i < int'(t0); i++) begin
                maxg = n - (t0 - i);
                case ($urandom % 4)
                    0:       g = 0;
                    1:       g = maxg;
                    default: g = $urandom_range(maxg, 0);
                endcase
                gap_q.push_back(g);
                n = n - g - 1;
            end
            build_expected(n0, t0);
            run_decode(n0, t0, 2, -1, 1'b0, "random", ab);
        end

`ifdef CW_DEC_ERR_EN
        begin
            bit saw_bit = 1'b0;
            bit saw_done = 1'b0;
            @(negedge clk);
            start = 1'b1; n_init = 21'd20; t_init = 4'd2;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                start     = 1'b0;
                gap_valid = gap_ready;
                gap       = 21'd20;
                bit_ready = 1'b1;
                if (bit_valid) saw_bit = 1'b1;
                if (done) saw_done = 1'b1;
            end
            gap_valid = 1'b0;
            check("err_set", err, 1);
            check("err_no_bits", saw_bit, 0);
            check("err_no_done", saw_done, 0);
            check("err_idle", busy, 0);
            load_vec(0);
            run_decode(20, 2, 0, -1, 1'b0, "err_clear", ab);
            check("err_cleared", err, 0);
            @(negedge clk);
            start = 1'b1; n_init = 21'd20; t_init = 4'd0;
            @(negedge clk);
            start = 1'b0;
            check("err_t0", err, 1);
            check("err_t0_idle", busy, 0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
